// File: rtl/hex_arb_if.sv
// Requester-side bus of the hexport arbiter: request levels and words in,
// grant pulse and current display state out.
interface hex_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]             gnt;
  logic [DATA_W-1:0]              hex_out;
  logic [2:0]                     owner;
  logic                           busy;

  modport master (output req, req_data, input gnt, hex_out, owner, busy);
  modport slave  (input req, req_data, output gnt, hex_out, owner, busy);
endinterface

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the seven-segment word with a minimum hold time.
// Optional HEX_ARB_PREEMPT_EN: requester 0 may cut into another owner's hold.
module hex_display_arbiter #(
  parameter int                NUM_REQ     = 4,
  parameter int                DATA_W      = 32,
  parameter int                HOLD_CYCLES = 1000,
  parameter logic [DATA_W-1:0] RESET_VAL   = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     reset_n,
  hex_arb_if.slave bus
);
  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] last;

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  int                   base;
  int                   off;
  logic [IDX_W-1:0]     win;
  logic                 win_vld;
  logic                 preempt;
  logic                 grant_en;
  logic [IDX_W-1:0]     grant_idx;

  // Rotate requests so bit 0 is the slot right after the last winner.
  always_comb begin
    base    = (int'(last) + 1) % NUM_REQ;
    dbl     = {bus.req, bus.req} >> base;
    rot     = dbl[NUM_REQ-1:0];
    win_vld = |rot;
    off     = 0;
    for (int p = NUM_REQ - 1; p >= 0; p--)
      if (rot[p]) off = p;
    win = IDX_W'((base + off) % NUM_REQ);
  end

`ifdef HEX_ARB_PREEMPT_EN
  assign preempt = (state == S_HOLD) && bus.req[0] && (bus.owner != 3'd0);
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    grant_en  = 1'b0;
    grant_idx = '0;
    if (preempt) begin
      grant_en  = 1'b1;
      grant_idx = '0;
    end else if (state == S_IDLE && win_vld) begin
      grant_en  = 1'b1;
      grant_idx = win;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last        <= IDX_W'(NUM_REQ - 1);
      bus.hex_out <= RESET_VAL;
      bus.gnt     <= '0;
      bus.owner   <= '0;
      bus.busy    <= 1'b0;
    end else begin
      bus.gnt <= '0;
      if (grant_en) begin
        bus.hex_out <= bus.req_data[grant_idx];
        bus.gnt     <= NUM_REQ'(1) << grant_idx;
        bus.owner   <= 3'(grant_idx);
        last        <= grant_idx;
        cnt         <= CNT_LOAD;
        bus.busy    <= 1'b1;
        state       <= S_HOLD;
      end else if (state == S_HOLD) begin
        if (cnt == '0) begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench: a time-based model predicts each grant; a negedge monitor checks it.
module tb_hex_display_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int H  = 4;
  localparam logic [DW-1:0] RV = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  hex_arb_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  hex_display_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .HOLD_CYCLES(H), .RESET_VAL(RV)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  typedef struct {
    int            cyc;
    int            w;
    logic [DW-1:0] data;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // Model state: arbitration is allowed from cycle free_at on.
  int            cyc = 0;
  int            free_at = 0;
  int            last = NR - 1;
  int            exp_owner = 0;
  logic          exp_busy = 1'b0;
  logic [DW-1:0] exp_hex = RV;
  logic [NR-1:0] hold_hi = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  always @(posedge clk) begin
    int w;
    logic [NR-1:0] r;
    cyc++;
    r = bus.req;
    w = -1;
    if (!reset_n) begin
      free_at   = cyc + 1;
      last      = NR - 1;
      exp_hex   = RV;
      exp_owner = 0;
      q.delete();
    end else begin
      if (cyc >= free_at) begin
        for (int j = 1; j <= NR; j++)
          if (w < 0 && r[(last + j) % NR]) w = (last + j) % NR;
      end
`ifdef HEX_ARB_PREEMPT_EN
      else if (r[0] && exp_owner != 0) w = 0;
`endif
    end
    if (w >= 0) begin
      exp_hex   = bus.req_data[w];
      exp_owner = w;
      last      = w;
      free_at   = cyc + H + 1;
      q.push_back('{cyc, w, exp_hex});
    end
    exp_busy = reset_n && (cyc <= free_at - 2);
  end

  always @(negedge clk) begin
    logic [NR-1:0] eg;
    exp_t e;
    eg = '0;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      eg[e.w] = 1'b1;
      chk("grant_data", bus.hex_out, e.data);
    end
    chk("gnt", bus.gnt, eg);
    chk("hex_out", bus.hex_out, exp_hex);
    chk("owner", bus.owner, exp_owner);
    chk("busy", bus.busy, exp_busy);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++)
        if (bus.gnt[i] && !hold_hi[i]) bus.req[i] = 1'b0;
    end
  endtask

  task automatic raise(input int i, input logic [DW-1:0] d);
    bus.req_data[i] = d;
    bus.req[i]      = 1'b1;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    reset_n      = 1'b0;
    step(2);
    reset_n = 1'b1;

    // lone request
    raise(2, 32'h1234_5678);
    step(8);

    // all four requesting continuously
    hold_hi = '1;
    raise(0, 32'hA0A0_0000);
    raise(1, 32'hB1B1_1111);
    raise(2, 32'hC2C2_2222);
    raise(3, 32'hD3D3_3333);
    step(26);
    hold_hi = '0;
    bus.req = '0;
    step(6);

    // request arriving during another owner's hold
    raise(3, 32'h3333_0003);
    step(2);
    raise(1, 32'hC0F9_A4B0);
    step(10);

    // reset two cycles into a hold, with others pending
    raise(2, 32'h2222_0002);
    step(1);
    raise(3, 32'h3333_0303);
    raise(1, 32'h1111_0101);
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(14);

    // host request during owner 2's hold
    raise(2, 32'h2222_2020);
    step(2);
    raise(0, 32'h0000_FEED);
    step(12);

    // random traffic with rare resets
    repeat (500) begin
      for (int i = 0; i < NR; i++)
        if (!bus.req[i] && $urandom_range(0, 9) == 0) raise(i, $urandom);
      reset_n = ($urandom_range(0, 99) != 0);
      step(1);
    end
    reset_n = 1'b1;
    bus.req = '0;
    step(12);

    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
